// File: rtl/leds.sv
// leds: free-running LED pattern generator (static/blink/chase/count); optional PWM dimming via LEDS_PWM_EN
module leds #(
  parameter int         MODE     = 0,
  parameter logic [3:0] PATTERN  = 4'b1111,
  parameter int         TICK_DIV = 12_000_000,
  parameter int         PWM_DUTY = 8
) (
  input  logic clk,
  input  logic rst,
  output logic LED1,
  output logic LED2,
  output logic LED3,
  output logic LED4
);
  localparam int DW = $clog2(TICK_DIV);
  localparam logic [DW-1:0] LAST = DW'(TICK_DIV - 1);
  logic [DW-1:0] r_div;
  logic          r_phase;
  logic [3:0]    r_pat;
  logic          w_tick;
  logic          w_en;
  logic [3:0]    w_rst_pat;
  logic [3:0]    w_next;
  assign w_tick = r_div == LAST;
  // prescaler wraps on the tick so the step period is exactly TICK_DIV clocks
  always_ff @(posedge clk)
    if (rst) r_div <= '0;
    else r_div <= w_tick ? '0 : r_div + 1'b1;
  // reset pattern and next step; modes outside 0..3 fall back to static
  always_comb begin
    w_rst_pat = MODE == 2 ? 4'b0001 : MODE == 3 ? 4'b0000 : PATTERN;
    w_next    = MODE == 1 ? (r_phase ? PATTERN : 4'b0000) :
                MODE == 2 ? {r_pat[2:0], r_pat[3]} :
                MODE == 3 ? r_pat + 4'd1 : PATTERN;
  end
  // pattern and blink phase advance only on the tick; reset wins
  always_ff @(posedge clk)
    if (rst) begin
      r_pat   <= w_rst_pat;
      r_phase <= 1'b0;
    end else if (w_tick) begin
      r_pat   <= w_next;
      r_phase <= ~r_phase;
    end
`ifdef LEDS_PWM_EN
  localparam logic [4:0] DUTY = 5'(PWM_DUTY);
  logic [3:0] r_slot;
  // 16-slot PWM frame; lit LEDs are on for the first DUTY slots
  always_ff @(posedge clk)
    if (rst) r_slot <= '0;
    else r_slot <= r_slot + 4'd1;
  assign w_en = {1'b0, r_slot} < DUTY;
`else
  assign w_en = 1'b1;
`endif
  assign {LED4, LED3, LED2, LED1} = r_pat & {4{w_en}};
endmodule

// File: tb/tb_leds.sv
// tb_leds: randomized-reset bench for leds against a step-count reference model
module tb_leds;
  localparam int N = 6;
  localparam int         MD [N] = '{0, 1, 2, 3, 7, 2};
  localparam logic [3:0] PT [N] = '{4'b1010, 4'b0110, 4'b1111, 4'b1111, 4'b1100, 4'b0101};
  localparam int         TD [N] = '{4, 4, 2, 2, 3, 5};
  localparam int         DU [N] = '{4, 0, 16, 8, 4, 12};
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [3:0] led [N];
  int tests = 0;
  int fails = 0;
  int n = 0;
  always #5 clk = ~clk;
  for (genvar g = 0; g < N; g++) begin : g_dut
    leds #(.MODE(MD[g]), .PATTERN(PT[g]), .TICK_DIV(TD[g]), .PWM_DUTY(DU[g])) u_dut (
      .clk(clk), .rst(rst),
      .LED1(led[g][0]), .LED2(led[g][1]), .LED3(led[g][2]), .LED4(led[g][3])
    );
  end
  task automatic check(input string tag, input logic [3:0] got, input logic [3:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s got=%b exp=%b", tag, got, exp);
    end
  endtask
  // expected LEDs after n clocks since the reset edge: pattern has stepped n/TICK_DIV times
  function automatic logic [3:0] model(input int i, input int cyc);
    int steps;
    logic [3:0] p;
    steps = cyc / TD[i];
    case (MD[i])
      1:       p = (steps % 2 == 0) ? PT[i] : 4'b0000;
      2:       p = 4'(1 << (steps % 4));
      3:       p = 4'(steps % 16);
      default: p = PT[i];
    endcase
`ifdef LEDS_PWM_EN
    if ((cyc % 16) >= DU[i]) p = 4'b0000;
`endif
    return p;
  endfunction
  initial begin
    for (int c = 0; c < 800; c++) begin
      @(negedge clk);
      rst = (c == 0) || (c >= 100 && $urandom_range(0, 39) == 0);
      @(posedge clk);
      n = rst ? 0 : n + 1;
      #1;
      for (int i = 0; i < N; i++)
        check($sformatf("u%0d_mode%0d_c%0d", i, MD[i], n), led[i], model(i, n));
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
